// File: rtl/cursor_input_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_input_ctrl
//
// Takes the raw board push-buttons and produces a cursor position on the
// minesweeper grid, a copy of that position latched at frame boundaries for
// the display, and a reveal request for the game logic.
//
// Each button goes through a 2-flop synchroniser and then its own debouncer.
// A debounced rising edge gives a one-cycle press pulse. Right/left and
// down/up move the cursor by one cell and saturate at the grid edges. Select
// raises a reveal request that carries the cell index under the cursor.
//
// Optional feature (macro CURSOR_AUTO_REPEAT_EN):
//   - Undefined (default): each press moves the cursor exactly once.
//   - Defined: a held direction fires again after REPEAT_DELAY cycles and
//     then every REPEAT_PERIOD cycles. Select never repeats.
//
// Ports:
//   clk          in   system clock; all logic runs on the rising edge
//   reset        in   asynchronous, active-low reset
//   left/right/up/down/select in   raw button levels, high = pressed
//   screen_end   in   frame-boundary level from the pixel-timing domain
//   cursor_x/y   out  live cursor column/row
//   disp_x/y     out  cursor column/row latched on each screen_end rise
//   reveal_valid out  a reveal request is pending
//   reveal_id    out  cursor_y*GRID_W + cursor_x, captured with the request
//   reveal_ready in   game logic accepts the request
//   dbg_state_o  out  reveal FSM state (0 = IDLE, 1 = REQ) for debug
//
// Reveal handshake: valid/ready. Once reveal_valid rises, it and reveal_id
// stay stable until a cycle in which reveal_ready is sampled high; the
// transfer happens on that edge and reveal_valid drops. reveal_ready is
// ignored while reveal_valid is low.
// -----------------------------------------------------------------------------
module cursor_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GRID_W          = 5,
  parameter int GRID_H          = 5
`ifdef CURSOR_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       select,
  input  logic       screen_end,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic [2:0] disp_x,
  output logic [2:0] disp_y,
  output logic       reveal_valid,
  output logic [5:0] reveal_id,
  input  logic       reveal_ready,
  output logic       dbg_state_o
);

  // Button bit order used everywhere below.
  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_SEL   = 4;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  logic [4:0]         btn_raw;
  logic [4:0]         btn_s1_q, btn_s2_q;
  logic [4:0]         stable_q, stable_d;
  logic [4:0]         stable_prev_q;
  logic [4:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [4:0]         press;
  logic [3:0]         move;

  logic               se_s1_q, se_s2_q, se_prev_q;
  logic               se_rise;

  logic [2:0]         x_q, x_d, y_q, y_d;
  logic [2:0]         disp_x_q, disp_x_d, disp_y_q, disp_y_d;

  state_t             state_q, state_d;
  logic [5:0]         id_q, id_d;
  logic [5:0]         cell_id;

  assign btn_raw = {select, down, up, right, left};

  // ---------------------------------------------------------------------------
  // Debounce: the counter only runs while the synced level disagrees with the
  // accepted level; the new level is accepted on the edge after the counter
  // has reached DEBOUNCE_CYCLES-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (btn_s2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = btn_s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

`ifdef CURSOR_AUTO_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat: each direction counts cycles since its press pulse (the
  // pulse cycle is count 0). The first repeat fires at REPEAT_DELAY; after a
  // fire the count restarts at 1 so later fires are REPEAT_PERIOD apart.
  // ---------------------------------------------------------------------------
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [3:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [3:0]         rpt_first_q, rpt_first_d;
  logic [3:0]         rpt_fire;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = '0;
    for (int i = 0; i < 4; i++) begin
      if (!stable_q[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b1;
      end else if (rpt_first_q[i] ? (rpt_cnt_q[i] == RW'(REPEAT_DELAY))
                                  : (rpt_cnt_q[i] == RW'(REPEAT_PERIOD))) begin
        rpt_fire[i]    = 1'b1;
        rpt_cnt_d[i]   = RW'(1);
        rpt_first_d[i] = 1'b0;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= '1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign move = press[3:0] | rpt_fire;
`else
  assign move = press[3:0];
`endif

  // ---------------------------------------------------------------------------
  // Cursor movement: opposite directions in the same cycle cancel.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (move[B_RIGHT] && !move[B_LEFT]) begin
      if (x_q != 3'(GRID_W - 1)) x_d = x_q + 3'd1;
    end else if (move[B_LEFT] && !move[B_RIGHT]) begin
      if (x_q != 3'd0) x_d = x_q - 3'd1;
    end
    if (move[B_DOWN] && !move[B_UP]) begin
      if (y_q != 3'(GRID_H - 1)) y_d = y_q + 3'd1;
    end else if (move[B_UP] && !move[B_DOWN]) begin
      if (y_q != 3'd0) y_d = y_q - 3'd1;
    end
  end

  // Frame latch takes the cursor as it stands before this edge's move.
  assign se_rise  = se_s2_q & ~se_prev_q;
  assign disp_x_d = se_rise ? x_q : disp_x_q;
  assign disp_y_d = se_rise ? y_q : disp_y_q;

  // ---------------------------------------------------------------------------
  // Reveal FSM
  // ---------------------------------------------------------------------------
  assign cell_id = 6'(y_q) * 6'(GRID_W) + 6'(x_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (press[B_SEL]) begin
          id_d    = cell_id;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (reveal_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q      <= '0;
      btn_s2_q      <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '0;
      se_s1_q       <= 1'b0;
      se_s2_q       <= 1'b0;
      se_prev_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      disp_x_q      <= '0;
      disp_y_q      <= '0;
      state_q       <= S_IDLE;
      id_q          <= '0;
    end else begin
      btn_s1_q      <= btn_raw;
      btn_s2_q      <= btn_s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
      se_s1_q       <= screen_end;
      se_s2_q       <= se_s1_q;
      se_prev_q     <= se_s2_q;
      x_q           <= x_d;
      y_q           <= y_d;
      disp_x_q      <= disp_x_d;
      disp_y_q      <= disp_y_d;
      state_q       <= state_d;
      id_q          <= id_d;
    end
  end

  assign cursor_x     = x_q;
  assign cursor_y     = y_q;
  assign disp_x       = disp_x_q;
  assign disp_y       = disp_y_q;
  assign reveal_valid = (state_q == S_REQ);
  assign reveal_id    = id_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cursor_input_ctrl.sv
module tb_cursor_input_ctrl;

  localparam int D  = 4;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk;
  logic       reset;
  logic       left, right, up, down, select;
  logic       screen_end;
  logic       reveal_ready;
  logic [2:0] cursor_x, cursor_y, disp_x, disp_y;
  logic       reveal_valid;
  logic [5:0] reveal_id;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: cursor as plain integers, pending reveal ids in a queue.
  int mx = 0;
  int my = 0;
  logic [5:0] exp_q[$];

  cursor_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .GRID_W(W),
    .GRID_H(H)
`ifdef CURSOR_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .left(left),
    .right(right),
    .up(up),
    .down(down),
    .select(select),
    .screen_end(screen_end),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .disp_x(disp_x),
    .disp_y(disp_y),
    .reveal_valid(reveal_valid),
    .reveal_id(reveal_id),
    .reveal_ready(reveal_ready),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // mask bit order: 0 left, 1 right, 2 up, 3 down, 4 select
  task automatic drive_btn(input logic [4:0] m);
    left   = m[0];
    right  = m[1];
    up     = m[2];
    down   = m[3];
    select = m[4];
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Apply the effect of one clean press to the model.
  task automatic model_press(input logic [4:0] m);
    if (m[4] && exp_q.size() == 0) exp_q.push_back(6'(my * W + mx));
    mx = clampi(mx + int'(m[1]) - int'(m[0]), W - 1);
    my = clampi(my + int'(m[3]) - int'(m[2]), H - 1);
  endtask

  // Clean press: hold, release, let both edges debounce, then compare.
  task automatic press(input logic [4:0] m, input int hold);
    drive_btn(m);
    steps(hold);
    drive_btn(5'b0);
    steps(D + 5);
    model_press(m);
    checks++;
    if (cursor_x !== 3'(mx)) begin
      errors++;
      $display("FAIL press_x: mask=%b got %0d expected %0d", m, cursor_x, mx);
    end
    checks++;
    if (cursor_y !== 3'(my)) begin
      errors++;
      $display("FAIL press_y: mask=%b got %0d expected %0d", m, cursor_y, my);
    end
    checks++;
    if (reveal_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL press_valid: got %0b expected %0b", reveal_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (reveal_id !== exp_q[0]) begin
        errors++;
        $display("FAIL press_id: got %0d expected %0d", reveal_id, exp_q[0]);
      end
    end
  endtask

  // Pulse shorter than the debounce window: must not change anything.
  task automatic glitch(input int bit_idx, input int len);
    logic [4:0] m;
    m = 5'b0;
    m[bit_idx] = 1'b1;
    drive_btn(m);
    steps(len);
    drive_btn(5'b0);
    steps(D + 5);
    checks++;
    if (cursor_x !== 3'(mx) || cursor_y !== 3'(my)) begin
      errors++;
      $display("FAIL glitch: bit=%0d len=%0d got (%0d,%0d) expected (%0d,%0d)",
               bit_idx, len, cursor_x, cursor_y, mx, my);
    end
    checks++;
    if (reveal_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL glitch_valid: got %0b expected %0b", reveal_valid, exp_q.size() != 0);
    end
  endtask

  // One-cycle ready; completes a pending request if there is one.
  task automatic handshake();
    logic exp_pend;
    exp_pend = (exp_q.size() != 0);
    checks++;
    if (reveal_valid !== exp_pend) begin
      errors++;
      $display("FAIL hs_valid_before: got %0b expected %0b", reveal_valid, exp_pend);
    end
    if (exp_pend) begin
      checks++;
      if (reveal_id !== exp_q[0]) begin
        errors++;
        $display("FAIL hs_id: got %0d expected %0d", reveal_id, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    reveal_ready = 1'b1;
    step();
    reveal_ready = 1'b0;
    checks++;
    if (reveal_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_valid_after: got %0b expected 0", reveal_valid);
    end
    steps(2);
  endtask

  task automatic frame_pulse_check();
    screen_end = 1'b1;
    step();
    screen_end = 1'b0;
    steps(2);
    checks++;
    if (disp_x !== 3'(mx) || disp_y !== 3'(my)) begin
      errors++;
      $display("FAIL frame_disp: got (%0d,%0d) expected (%0d,%0d)", disp_x, disp_y, mx, my);
    end
    steps(2);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    drive_btn(5'b0);
    screen_end   = 1'b0;
    reveal_ready = 1'b0;
    steps(3);
    mx = 0;
    my = 0;
    exp_q.delete();
    checks++;
    if ({cursor_x, cursor_y, disp_x, disp_y} !== 12'd0) begin
      errors++;
      $display("FAIL reset_pos: got %h expected 000", {cursor_x, cursor_y, disp_x, disp_y});
    end
    checks++;
    if (reveal_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b expected 0", reveal_valid);
    end
    checks++;
    if (reveal_id !== 6'd0) begin
      errors++;
      $display("FAIL reset_id: got %0d expected 0", reveal_id);
    end
    reset = 1'b1;
    steps(2);
    checks++;
    if ({cursor_x, cursor_y, reveal_valid} !== 7'd0) begin
      errors++;
      $display("FAIL reset_release: got %h expected 0", {cursor_x, cursor_y, reveal_valid});
    end
  endtask

  task automatic test_single_press();
    right = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (cursor_x !== ((e >= D + 3) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL single_latency: edge %0d got %0d expected %0d", e, cursor_x,
                 (e >= D + 3) ? 1 : 0);
      end
      checks++;
      if (cursor_y !== 3'd0) begin
        errors++;
        $display("FAIL single_y: edge %0d got %0d expected 0", e, cursor_y);
      end
    end
    right = 1'b0;
    steps(D + 5);
    mx = 1;
  endtask

  task automatic test_glitch_clamp();
    glitch(1, 2);
    for (int i = 0; i < 3; i++) glitch($urandom_range(0, 4), $urandom_range(1, D - 1));
    for (int i = 0; i < 7; i++) press(5'b00010, D + 1);
    checks++;
    if (cursor_x !== 3'd4) begin
      errors++;
      $display("FAIL clamp_right: got %0d expected 4", cursor_x);
    end
    press(5'b00011, D + 2);
    checks++;
    if (cursor_x !== 3'd4) begin
      errors++;
      $display("FAIL both_lr: got %0d expected 4", cursor_x);
    end
    for (int i = 0; i < 6; i++) press(5'b00100, D + 1);
    checks++;
    if (cursor_y !== 3'd0) begin
      errors++;
      $display("FAIL clamp_up: got %0d expected 0", cursor_y);
    end
  endtask

  task automatic test_frame_latch();
    press(5'b00001, D + 1);
    press(5'b01000, D + 1);
    press(5'b01000, D + 1);
    checks++;
    if (disp_x !== 3'd0 || disp_y !== 3'd0) begin
      errors++;
      $display("FAIL frame_hold: got (%0d,%0d) expected (0,0)", disp_x, disp_y);
    end
    screen_end = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      screen_end = 1'b0;
      checks++;
      if (e < 3 && (disp_x !== 3'd0 || disp_y !== 3'd0)) begin
        errors++;
        $display("FAIL frame_early: edge %0d got (%0d,%0d) expected (0,0)", e, disp_x, disp_y);
      end else if (e == 3 && (disp_x !== 3'd3 || disp_y !== 3'd2)) begin
        errors++;
        $display("FAIL frame_latch: got (%0d,%0d) expected (3,2)", disp_x, disp_y);
      end
    end
    steps(2);
  endtask

  task automatic test_reveal();
    press(5'b00001, D + 1);
    press(5'b01000, D + 1);
    select = 1'b1;
    for (int e = 1; e <= D + 3; e++) begin
      step();
      checks++;
      if (reveal_valid !== (e >= D + 3)) begin
        errors++;
        $display("FAIL reveal_rise: edge %0d got %0b expected %0b", e, reveal_valid, e >= D + 3);
      end
    end
    checks++;
    if (reveal_id !== 6'd17) begin
      errors++;
      $display("FAIL reveal_id: got %0d expected 17", reveal_id);
    end
    exp_q.push_back(6'(my * W + mx));
    steps(2);
    select = 1'b0;
    steps(D + 5);
    press(5'b10000, D + 2);
    press(5'b00010, D + 1);
    checks++;
    if (reveal_id !== 6'd17 || reveal_valid !== 1'b1) begin
      errors++;
      $display("FAIL reveal_hold: got id %0d valid %0b expected id 17 valid 1",
               reveal_id, reveal_valid);
    end
    handshake();
    reveal_ready = 1'b1;
    steps(3);
    reveal_ready = 1'b0;
    checks++;
    if (reveal_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_idle: got %0b expected 0", reveal_valid);
    end
  endtask

  task automatic test_reset_mid();
    press(5'b10000, D + 1);
    right = 1'b1;
    steps(4);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cursor_x, cursor_y, disp_x, disp_y, reveal_valid, reveal_id} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0",
               {cursor_x, cursor_y, disp_x, disp_y, reveal_valid, reveal_id});
    end
    right = 1'b0;
    steps(2);
    reset = 1'b1;
    mx = 0;
    my = 0;
    exp_q.delete();
    steps(2);
    right = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (cursor_x !== ((e >= D + 3) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL reset_fresh: edge %0d got %0d expected %0d", e, cursor_x,
                 (e >= D + 3) ? 1 : 0);
      end
    end
    right = 1'b0;
    steps(D + 5);
    mx = 1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: press({1'b0, 4'($urandom_range(0, 15))}, $urandom_range(D, D + 8));
        2:    glitch($urandom_range(0, 4), $urandom_range(1, D - 1));
        3:    press(5'b10000, $urandom_range(D, D + 8));
        4:    handshake();
        default: frame_pulse_check();
      endcase
    end
    handshake();
  endtask

`ifdef CURSOR_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int fires;
    test_reset();
    down = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      fires = 0;
      if (e >= D + 3) fires = 1;
      if (e >= D + 3 + RD) fires = 2 + (e - (D + 3 + RD)) / RP;
      checks++;
      if (cursor_y !== 3'(clampi(fires, H - 1))) begin
        errors++;
        $display("FAIL repeat_y: edge %0d got %0d expected %0d", e, cursor_y,
                 clampi(fires, H - 1));
      end
    end
    down = 1'b0;
    steps(D + 5);
    my = H - 1;
    checks++;
    if (cursor_y !== 3'(my) || cursor_x !== 3'd0) begin
      errors++;
      $display("FAIL repeat_end: got (%0d,%0d) expected (0,%0d)", cursor_x, cursor_y, my);
    end
  endtask
`else
  task automatic test_hold_no_repeat();
    int x0;
    x0 = mx;
    right = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e >= D + 3) begin
        checks++;
        if (cursor_x !== 3'(clampi(x0 + 1, W - 1))) begin
          errors++;
          $display("FAIL hold_once: edge %0d got %0d expected %0d", e, cursor_x,
                   clampi(x0 + 1, W - 1));
        end
      end
    end
    right = 1'b0;
    steps(D + 5);
    mx = clampi(x0 + 1, W - 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch_clamp();
    test_frame_latch();
    test_reveal();
    test_reset_mid();
    test_random();
`ifdef CURSOR_AUTO_REPEAT_EN
    test_auto_repeat();
`else
    test_hold_no_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
